// File: rtl/ma_seq_ctrl_pkg.sv
// Shared definitions for the moving-average sequencer: state codes, default phase
// count and the counter-width helper.
package ma_seq_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam int ENG_PHASES_DEF = 3;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ma_seq_ctrl_if.sv
// Valid/ready stream used for both the sample input and the result output.
// A beat transfers on any rising edge where valid and ready are both high; once
// valid is raised, the source holds valid and data until that edge.
interface ma_seq_ctrl_if #(
  parameter int W = 64
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ma_seq_ctrl.sv
// Sequencer for the 3-phase moving-average engine: accepts samples, steps the engine,
// and emits results once the window is full. Optional MA_SEQ_CTRL_CNT_EN adds sample_cnt.
module ma_seq_ctrl
  import ma_seq_ctrl_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MA_LEN     = 3,
  parameter int ENG_PHASES = ENG_PHASES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ma_seq_ctrl_if.slave      in_if,
  input  logic              flush,
  output logic              eng_en,
  output logic              eng_rst,
  output logic [DATA_W-1:0] eng_data,
  input  logic [DATA_W-1:0] eng_out,
  ma_seq_ctrl_if.master     out_if,
  output logic              warm,
  output logic              busy,
  output logic [1:0]        dbg_state
`ifdef MA_SEQ_CTRL_CNT_EN
  ,
  output logic [31:0]       sample_cnt
`endif
);

    localparam int FILL_W = cnt_w(MA_LEN);
    localparam int PH_W   = cnt_w(ENG_PHASES);
    localparam logic [FILL_W:0]   MA_LEN_X = MA_LEN[FILL_W:0];
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(ENG_PHASES - 1);

    logic [1:0]        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [FILL_W:0]   fill_inc;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] eng_data_q, eng_data_d;
    logic              accept;

    // Flush and reset both mask the handshake and the engine enable for that cycle.
    assign in_if.ready  = (state_q == ST_IDLE) && !flush && !rst;
    assign accept       = in_if.ready && in_if.valid;
    assign eng_en       = (state_q == ST_RUN) && !flush && !rst;
    assign eng_rst      = rst || flush;
    assign eng_data     = eng_data_q;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
    assign warm         = ({1'b0, fill_q} == MA_LEN_X);
    assign busy         = (state_q != ST_IDLE);
    assign dbg_state    = state_q;
    assign fill_inc     = {1'b0, fill_q} + 1'b1;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        eng_data_d  = eng_data_q;
        if (flush) begin
            state_d     = ST_IDLE;
            phase_d     = '0;
            fill_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        eng_data_d = in_if.data;
                        phase_d    = '0;
                        state_d    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PH_LAST) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    out_data_d = eng_out;
                    // Results before the window fills are captured but never offered.
                    if (fill_inc >= MA_LEN_X) begin
                        fill_d      = MA_LEN_X[FILL_W-1:0];
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        fill_d  = fill_inc[FILL_W-1:0];
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (out_if.ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            eng_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            eng_data_q  <= eng_data_d;
        end
    end

`ifdef MA_SEQ_CTRL_CNT_EN
    logic [31:0] sample_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || flush) sample_cnt_q <= '0;
        else if (accept)  sample_cnt_q <= sample_cnt_q + 32'd1;
    end

    assign sample_cnt = sample_cnt_q;
`endif

endmodule
